// File: rtl/phase_seq_pkg.sv
// Shared definitions for the one-hot phase sequencer: state encodings
// and a width helper used by the top and the dwell counter.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_seq_dwell_cnt.sv
// Per-phase tick counter. Counts tick strobes from 0 to DWELL-1 and
// flags the final count so the sequencer knows when to advance.
module dwell_cnt
  import phase_seq_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clr,
  input  logic en,
  input  logic hold,
  output logic last
);

  localparam int CW = min1_clog2(DWELL);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear beats hold, hold beats a tick; wraps at the last count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (hold) begin
      count_d = count_q;
    end else if (en) begin
      if (count_q == LAST_CNT) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Count register, cleared asynchronously on reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/phase_seq.sv
// One-hot phase sequencer: steps an NPHASE-wide one-hot vector, dwelling
// DWELL ticks per phase, with pause/resume, clear and loop/one-shot modes.
// All outputs come straight from registers.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int NPHASE = 5,
  parameter int DWELL  = 4,
  localparam int IW    = min1_clog2(NPHASE)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              tick,
  input  logic              loop,
  output logic [NPHASE-1:0] q,
  output logic [IW-1:0]     idx,
  output logic              running,
  output logic              wrap,
  output logic              done
);

  localparam logic [IW-1:0]     LAST_IDX    = IW'(NPHASE - 1);
  localparam logic [NPHASE-1:0] FIRST_PHASE = NPHASE'(1);

  state_e            state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              loop_q, loop_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_hold;
  logic cnt_last;

  dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .hold (cnt_hold),
    .last (cnt_last)
  );

  // Next-state, phase vector and pulse logic; priority clear > stop > start.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    loop_d   = loop_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_hold = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      phase_d = '0;
      idx_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
            phase_d = FIRST_PHASE;
            idx_d   = '0;
            loop_d  = loop;
            cnt_clr = 1'b1;
          end
        end

        ST_RUN: begin
          cnt_en   = tick;
          cnt_hold = stop;
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick && cnt_last) begin
            if (idx_q == LAST_IDX) begin
              if (loop_q) begin
                phase_d = FIRST_PHASE;
                idx_d   = '0;
                wrap_d  = 1'b1;
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              phase_d = phase_q << 1;
              idx_d   = idx_q + IW'(1);
            end
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            state_d = ST_IDLE;
            phase_d = '0;
            idx_d   = '0;
            cnt_clr = 1'b1;
          end else if (start) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          if (stop) begin
            state_d = ST_IDLE;
            phase_d = '0;
            idx_d   = '0;
            cnt_clr = 1'b1;
          end else if (start) begin
            state_d = ST_RUN;
            phase_d = FIRST_PHASE;
            idx_d   = '0;
            loop_d  = loop;
            cnt_clr = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State, phase and pulse registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign q       = phase_q;
  assign idx     = idx_q;
  assign running = (state_q == ST_RUN);
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule

// File: tb/tb_phase_seq.sv
// Randomised and directed bench for phase_seq (NPHASE=5, DWELL=2),
// checked against an elapsed-tick reference model.
module tb_phase_seq;
  import phase_seq_pkg::*;

  localparam int NPHASE = 5;
  localparam int DWELL  = 2;
  localparam int IW     = 3;
  localparam int TOTAL  = NPHASE * DWELL;

  logic              CLK;
  logic              RSTN;
  logic              start;
  logic              stop;
  logic              clear;
  logic              tick;
  logic              loop;
  logic [NPHASE-1:0] q;
  logic [IW-1:0]     idx;
  logic              running;
  logic              wrap;
  logic              done;

  int errCount;
  int checkCount;

  // Reference model: mode plus ticks elapsed since phase 0 of this pass.
  state_e modeM;
  int     posM;
  logic   loopM;
  logic   wrapM;
  logic   doneM;

  phase_seq #(
    .NPHASE(NPHASE),
    .DWELL (DWELL)
  ) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .tick   (tick),
    .loop   (loop),
    .q      (q),
    .idx    (idx),
    .running(running),
    .wrap   (wrap),
    .done   (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model reset to power-on values.
  task automatic modelReset();
    modeM = ST_IDLE;
    posM  = 0;
    loopM = 1'b0;
    wrapM = 1'b0;
    doneM = 1'b0;
  endtask

  // Advances the model by one clock edge using the inputs just applied.
  task automatic modelStep(input logic st, input logic sp, input logic cl,
                           input logic tk, input logic lp);
    wrapM = 1'b0;
    doneM = 1'b0;
    if (cl) begin
      modeM = ST_IDLE;
      posM  = 0;
    end else begin
      case (modeM)
        ST_IDLE: if (!sp && st) begin
          modeM = ST_RUN; posM = 0; loopM = lp;
        end
        ST_RUN: if (sp) begin
          modeM = ST_PAUSE;
        end else if (tk) begin
          posM++;
          if (posM == TOTAL) begin
            if (loopM) begin
              posM = 0; wrapM = 1'b1;
            end else begin
              modeM = ST_DONE; posM = TOTAL - 1; doneM = 1'b1;
            end
          end
        end
        ST_PAUSE: if (sp) begin
          modeM = ST_IDLE; posM = 0;
        end else if (st) begin
          modeM = ST_RUN;
        end
        default: if (sp) begin
          modeM = ST_IDLE; posM = 0;
        end else if (st) begin
          modeM = ST_RUN; posM = 0; loopM = lp;
        end
      endcase
    end
  endtask

  // Compares every output against the model.
  task automatic checkAll(input string tag);
    int ph;
    logic [31:0] expQ;
    logic [31:0] expIdx;
    ph     = posM / DWELL;
    expQ   = (modeM == ST_IDLE) ? 32'd0 : (32'd1 << ph);
    expIdx = (modeM == ST_IDLE) ? 32'd0 : 32'(ph);
    checkOutput({tag, ".q"}, 32'(q), expQ);
    checkOutput({tag, ".idx"}, 32'(idx), expIdx);
    checkOutput({tag, ".running"}, 32'(running), 32'(modeM == ST_RUN));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(wrapM));
    checkOutput({tag, ".done"}, 32'(done), 32'(doneM));
    checkOutput({tag, ".onehot"}, 32'($onehot0(q)), 32'd1);
  endtask

  // Drives one cycle of inputs, clocks DUT and model, then checks.
  task automatic applyStimulus(input string tag, input logic st, input logic sp,
                               input logic cl, input logic tk, input logic lp);
    start = st; stop = sp; clear = cl; tick = tk; loop = lp;
    @(posedge CLK);
    modelStep(st, sp, cl, tk, lp);
    #1;
    checkAll(tag);
  endtask

  initial begin
    errCount = 0;
    checkCount = 0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; loop = 1'b0;
    RSTN = 1'b0;
    modelReset();
    #12;
    checkAll("por");
    @(negedge CLK);
    RSTN = 1'b1;

    $display("[TB] loop run with tick every cycle");
    applyStimulus("loopStart", 1, 0, 0, 1, 1);
    for (int i = 0; i < 14; i++) applyStimulus("loopRun", 0, 0, 0, 1, 0);

    $display("[TB] asynchronous reset mid-run");
    #2 RSTN = 1'b0;
    #1;
    checkOutput("asyncRst.q", 32'(q), 32'd0);
    checkOutput("asyncRst.running", 32'(running), 32'd0);
    modelReset();
    @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("rstHold", 0, 0, 0, 1, 1);

    $display("[TB] one-shot run");
    applyStimulus("oneShotStart", 1, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) applyStimulus("oneShotRun", 0, 0, 0, 1, 1);
    applyStimulus("restartFromDone", 1, 0, 0, 1, 1);

    $display("[TB] pause and resume");
    applyStimulus("pauseStop0", 0, 1, 0, 0, 0);
    applyStimulus("pauseStop1", 0, 1, 0, 0, 0);
    applyStimulus("pauseStart", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("pauseTicks", 0, 0, 0, 1, 0);
    applyStimulus("pauseStopTick", 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("pausedTicks", 0, 0, 0, 1, 0);
    applyStimulus("resume", 1, 0, 0, 0, 0);
    applyStimulus("resumeTick", 0, 0, 0, 1, 0);
    applyStimulus("pause2", 0, 1, 0, 0, 0);
    applyStimulus("stopToIdle", 0, 1, 0, 0, 0);

    $display("[TB] start/stop collision and clear");
    applyStimulus("startStopIdle", 1, 1, 0, 1, 0);
    applyStimulus("runAgain", 1, 0, 0, 1, 1);
    applyStimulus("runTick", 0, 0, 0, 1, 1);
    applyStimulus("clearStart", 1, 0, 1, 1, 1);

    $display("[TB] tick every third cycle");
    applyStimulus("slowStart", 1, 0, 0, 0, 1);
    for (int i = 0; i < 66; i++) applyStimulus("slowRun", 0, 0, 0, (i % 3) == 2, 0);
    applyStimulus("slowClear", 0, 0, 1, 1, 0);

    $display("[TB] randomised stimulus");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus("random",
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
